// File: rtl/user_btn_conditioner.sv
// user_btn_conditioner: synchronise, debounce and event-decode the raw board push-button
module user_btn_conditioner #(
    parameter logic        ACTIVE_LOW      = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 12000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long_press,
    output logic       o_release_was_long,
    output logic [7:0] o_press_count
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_flag_q, long_flag_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              was_long_q, was_long_d;
    logic [7:0]        count_q, count_d;
    logic              btn_s;

    assign btn_s              = sync2_q ^ ACTIVE_LOW;
    assign o_level            = level_q;
    assign o_press            = press_q;
    assign o_release          = release_q;
    assign o_long_press       = long_q;
    assign o_release_was_long = was_long_q;
    assign o_press_count      = count_q;

    // Next-state, counters and registered event pulses; pulses default low so they last one cycle
    always_comb begin
        sync1_d     = i_btn;
        sync2_d     = sync1_q;
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        count_d     = count_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        was_long_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    hold_cnt_d  = '0;
                    long_flag_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = LONG_HELD;
                    long_d      = 1'b1;
                    long_flag_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (!btn_s) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end
            end
            RELEASE_DB: begin
                if (btn_s) begin
                    state_d = long_flag_q ? LONG_HELD : HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = IDLE;
                    level_d    = 1'b0;
                    release_d  = 1'b1;
                    was_long_d = long_flag_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; synchroniser resets to the pin's idle level so reset never looks like a press
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q     <= ACTIVE_LOW;
            sync2_q     <= ACTIVE_LOW;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            was_long_q  <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            was_long_q  <= was_long_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_user_btn_conditioner.sv
// tb_user_btn_conditioner: directed table and sequence checks of the button conditioner
module tb_user_btn_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       btn2 = 1'b1;
    logic       level, press, rel, lng, wl;
    logic [7:0] cnt;
    logic       level2, press2, rel2, lng2, wl2;
    logic [7:0] cnt2;

    user_btn_conditioner #(.ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_level(level), .o_press(press),
        .o_release(rel), .o_long_press(lng), .o_release_was_long(wl), .o_press_count(cnt)
    );

    user_btn_conditioner #(.ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_btn(btn2), .o_level(level2), .o_press(press2),
        .o_release(rel2), .o_long_press(lng2), .o_release_was_long(wl2), .o_press_count(cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        int   n;
        int   press;
        int   rel;
        int   lng;
        int   wl;
        logic lvl;
        int   cnt;
    } row_t;

    row_t rows[18];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_press, n_rel, n_long, n_wl, press_cyc, rel_cyc, long_cyc;
    int   n_press2 = 0, n_rel2 = 0, press2_cyc = 0;
    int   viol = 0;
    int   e0;
    logic lvl_at_press, lvl_at_rel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        n_press = 0; n_rel = 0; n_long = 0; n_wl = 0;
        press_cyc = -1; rel_cyc = -1; long_cyc = -1;
        lvl_at_press = 1'b0; lvl_at_rel = 1'b1;
    endtask

    task automatic step(input logic b);
        btn = b;
        @(negedge clk);
        cyc++;
        if (press) begin n_press++; press_cyc = cyc; lvl_at_press = level; end
        if (rel) begin n_rel++; rel_cyc = cyc; lvl_at_rel = level; if (wl) n_wl++; end
        if (lng) begin n_long++; long_cyc = cyc; end
        if (wl && !rel) viol++;
        if (int'(press) + int'(rel) + int'(lng) > 1) viol++;
        if (press2) begin n_press2++; press2_cyc = cyc; end
        if (rel2) n_rel2++;
        if (wl2 && !rel2) viol++;
    endtask

    initial begin
        for (int i = 0; i < 10; i += 2) begin
            rows[i]     = '{1'b1, 3, 0, 0, 0, 0, 1'b0, 1};
            rows[i + 1] = '{1'b0, 3, 0, 0, 0, 0, 1'b0, 1};
        end
        rows[10] = '{1'b1, 4,  0, 0, 0, 0, 1'b0, 1};
        rows[11] = '{1'b0, 8,  0, 0, 0, 0, 1'b0, 1};
        rows[12] = '{1'b1, 5,  0, 0, 0, 0, 1'b0, 1};
        rows[13] = '{1'b0, 10, 1, 1, 0, 0, 1'b0, 2};
        rows[14] = '{1'b1, 30, 1, 0, 1, 0, 1'b1, 3};
        rows[15] = '{1'b0, 10, 0, 1, 0, 1, 1'b0, 3};
        rows[16] = '{1'b1, 10, 1, 0, 0, 0, 1'b1, 4};
        rows[17] = '{1'b0, 10, 0, 1, 0, 0, 1'b0, 4};

        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {level, press, rel, lng, wl, cnt}, 0);
        chk("reset_outputs_al", {level2, press2, rel2, lng2, wl2, cnt2}, 0);
        rst = 1'b0;
        repeat (3) step(1'b0);

        clr();
        e0 = cyc + 1;
        repeat (10) step(1'b1);
        chk("clean_press_latency", press_cyc, e0 + 6);
        chk("clean_press_level", lvl_at_press, 1);
        chk("clean_press_single", n_press, 1);
        chk("clean_press_count", cnt, 1);
        chk("clean_press_no_long", n_long, 0);
        repeat (10) step(1'b0);
        chk("clean_release", n_rel, 1);
        chk("clean_release_level", level, 0);

        for (int i = 0; i < 18; i++) begin
            clr();
            repeat (rows[i].n) step(rows[i].btn);
            chk($sformatf("row%0d_press", i), n_press, rows[i].press);
            chk($sformatf("row%0d_release", i), n_rel, rows[i].rel);
            chk($sformatf("row%0d_long", i), n_long, rows[i].lng);
            chk($sformatf("row%0d_was_long", i), n_wl, rows[i].wl);
            chk($sformatf("row%0d_level", i), level, rows[i].lvl);
            chk($sformatf("row%0d_count", i), cnt, rows[i].cnt);
        end

        clr();
        e0 = cyc + 1;
        repeat (40) step(1'b1);
        chk("long_press_latency", press_cyc, e0 + 6);
        chk("long_after_press", long_cyc - press_cyc, 20);
        chk("long_no_repeat", n_long, 1);
        e0 = cyc + 1;
        repeat (10) step(1'b0);
        chk("long_release_latency", rel_cyc, e0 + 6);
        chk("long_release_was_long", n_wl, 1);
        chk("long_release_level", lvl_at_rel, 0);

        clr();
        e0 = cyc + 1;
        repeat (10) step(1'b1);
        repeat (2) step(1'b0);
        repeat (30) step(1'b1);
        chk("bounce_press_latency", press_cyc, e0 + 6);
        chk("bounce_no_release", n_rel, 0);
        chk("bounce_level", level, 1);
        chk("bounce_long_frozen", long_cyc, e0 + 29);
        chk("bounce_long_once", n_long, 1);
        repeat (10) step(1'b0);
        chk("bounce_release_was_long", n_wl, 1);

        clr();
        repeat (12) step(1'b1);
        chk("rstmid_held", level, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_async_outputs", {level, press, rel, lng, wl, cnt}, 0);
        repeat (3) step(1'b1);
        rst = 1'b0;
        e0 = cyc + 1;
        repeat (10) step(1'b1);
        chk("rstmid_repress_latency", press_cyc, e0 + 6);
        chk("rstmid_no_release", n_rel, 0);
        chk("rstmid_count", cnt, 1);
        repeat (10) step(1'b0);

        rst = 1'b1;
        repeat (2) step(1'b0);
        rst = 1'b0;
        repeat (2) step(1'b0);
        clr();
        repeat (255) begin
            repeat (6) step(1'b1);
            repeat (7) step(1'b0);
        end
        chk("wrap_count_255", cnt, 255);
        repeat (6) step(1'b1);
        repeat (7) step(1'b0);
        chk("wrap_count_0", cnt, 0);
        chk("wrap_presses", n_press, 256);

        chk("al_idle_no_press", n_press2, 0);
        e0 = cyc + 1;
        btn2 = 1'b0;
        repeat (10) step(1'b0);
        chk("al_press_latency", press2_cyc, e0 + 6);
        chk("al_level", level2, 1);
        chk("al_count", cnt2, 1);
        btn2 = 1'b1;
        repeat (10) step(1'b0);
        chk("al_release", n_rel2, 1);
        chk("al_release_level", level2, 0);

        chk("pulse_rules", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
